// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings for the writeback stage (wb_sel, load funct3,
//               FSM state type).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam logic [1:0] c_wb_sel_alu  = 2'd0;
  localparam logic [1:0] c_wb_sel_mem  = 2'd1;
  localparam logic [1:0] c_wb_sel_link = 2'd2;
  localparam logic [1:0] c_wb_sel_rsvd = 2'd3;

  localparam logic [2:0] c_f3_lb  = 3'd0;
  localparam logic [2:0] c_f3_lh  = 3'd1;
  localparam logic [2:0] c_f3_lw  = 3'd2;
  localparam logic [2:0] c_f3_lbu = 3'd4;
  localparam logic [2:0] c_f3_lhu = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_stage_pipe_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Combinational load-data extract and sign/zero extension with
//               misalignment and illegal-funct3 detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_byte_off,
  output logic [XLEN-1:0] o_data,
  output logic            o_misaligned,
  output logic            o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw[{i_byte_off, 3'b000} +: 8];
  assign w_half = i_raw[{i_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data       = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      c_f3_lb:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_f3_lbu: o_data = {{(XLEN-8){1'b0}}, w_byte};
      c_f3_lh: begin
        o_data       = {{(XLEN-16){w_half[15]}}, w_half};
        o_misaligned = i_byte_off[0];
      end
      c_f3_lhu: begin
        o_data       = {{(XLEN-16){1'b0}}, w_half};
        o_misaligned = i_byte_off[0];
      end
      c_f3_lw: begin
        o_data       = i_raw;
        o_misaligned = |i_byte_off;
      end
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage_pipe.sv
// ============================================================================
// Module      : wb_stage_pipe
// Description : Registered, handshaked RV32 writeback stage with late load
//               response, sub-word alignment and fault reporting.
//               Optional WB_STAGE_RETIRE_CNT_EN adds retire_pulse/instret.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [XLEN-1:0]           in_alu_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_reg_write,
  input  logic [1:0]                in_wb_sel,
  input  logic [2:0]                in_funct3,
  input  logic [1:0]                in_byte_off,
  input  logic                      mem_rsp_valid,
  input  logic [XLEN-1:0]           mem_rsp_data,
  input  logic                      mem_rsp_err,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      load_pending,
  output logic [REG_ADDR_WIDTH-1:0] load_pending_rd,
  output logic                      load_fault
`ifdef WB_STAGE_RETIRE_CNT_EN
  ,
  output logic                      retire_pulse,
  output logic [63:0]               instret
`endif
);

  wb_state_t                 r_state;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [2:0]                r_funct3;
  logic [1:0]                r_byte_off;
  logic                      r_reg_write;
  logic                      r_rf_we;
  logic [REG_ADDR_WIDTH-1:0] r_rf_waddr;
  logic [XLEN-1:0]           r_rf_wdata;
  logic                      r_load_fault;

  logic                      w_accept;
  logic                      w_is_load;
  logic [PC_WIDTH-1:0]       w_pc4;
  logic [XLEN-1:0]           w_nonload_data;
  logic [XLEN-1:0]           w_ld_data;
  logic                      w_ld_misaligned;
  logic                      w_ld_illegal;
  logic                      w_ld_fault;
  logic                      w_retire;

  assign in_ready        = (r_state == ST_IDLE);
  assign w_accept        = in_valid && in_ready;
  assign w_is_load       = (in_wb_sel == c_wb_sel_mem);
  assign w_pc4           = in_pc + PC_WIDTH'(4);
  assign load_pending    = (r_state == ST_WAIT_MEM);
  assign load_pending_rd = load_pending ? r_rd : '0;

  // Reserved select falls through to the ALU result.
  always_comb begin
    w_nonload_data = in_alu_data;
    if (in_wb_sel == c_wb_sel_link) begin
      w_nonload_data                 = '0;
      w_nonload_data[PC_WIDTH-1:0]   = w_pc4;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_raw        (mem_rsp_data),
    .i_funct3     (r_funct3),
    .i_byte_off   (r_byte_off),
    .o_data       (w_ld_data),
    .o_misaligned (w_ld_misaligned),
    .o_illegal    (w_ld_illegal)
  );

  assign w_ld_fault = w_ld_misaligned || w_ld_illegal || mem_rsp_err;

  // An instruction retires when it leaves the stage without a fault,
  // regardless of whether it actually writes the register file.
  assign w_retire = ((r_state == ST_IDLE) && w_accept && !w_is_load) ||
                    ((r_state == ST_WAIT_MEM) && mem_rsp_valid && !w_ld_fault);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_byte_off   <= '0;
      r_reg_write  <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_load_fault <= 1'b0;
    end else begin
      r_rf_we      <= 1'b0;
      r_load_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_load) begin
              r_state     <= ST_WAIT_MEM;
              r_rd        <= in_rd;
              r_funct3    <= in_funct3;
              r_byte_off  <= in_byte_off;
              r_reg_write <= in_reg_write;
            end else if (in_reg_write && (in_rd != '0)) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= in_rd;
              r_rf_wdata <= w_nonload_data;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rsp_valid) begin
            r_state <= ST_IDLE;
            if (w_ld_fault) begin
              r_load_fault <= 1'b1;
            end else if (r_reg_write && (r_rd != '0)) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= r_rd;
              r_rf_wdata <= w_ld_data;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign load_fault = r_load_fault;

`ifdef WB_STAGE_RETIRE_CNT_EN
  logic        r_retire_pulse;
  logic [63:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_pulse <= 1'b0;
      r_instret      <= '0;
    end else begin
      r_retire_pulse <= w_retire;
      if (w_retire) r_instret <= r_instret + 64'd1;
    end
  end

  assign retire_pulse = r_retire_pulse;
  assign instret      = r_instret;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
// ============================================================================
// Module      : tb_wb_stage_pipe
// Description : Directed, table-driven self-checking bench for wb_stage_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_byte_off;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_pending;
  logic [4:0]  load_pending_rd;
  logic        load_fault;
`ifdef WB_STAGE_RETIRE_CNT_EN
  logic        retire_pulse;
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;
  longint unsigned exp_instret = 0;

  wb_stage_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_alu_data     (in_alu_data),
    .in_rd           (in_rd),
    .in_reg_write    (in_reg_write),
    .in_wb_sel       (in_wb_sel),
    .in_funct3       (in_funct3),
    .in_byte_off     (in_byte_off),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .mem_rsp_err     (mem_rsp_err),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .load_pending    (load_pending),
    .load_pending_rd (load_pending_rd),
    .load_fault      (load_fault)
`ifdef WB_STAGE_RETIRE_CNT_EN
    ,
    .retire_pulse    (retire_pulse),
    .instret         (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instret(input string name);
`ifdef WB_STAGE_RETIRE_CNT_EN
    chk(name, instret, exp_instret);
`else
    checks = checks + 0;
`endif
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_pc         = '0;
    in_alu_data   = '0;
    in_rd         = '0;
    in_reg_write  = 1'b0;
    in_wb_sel     = 2'd0;
    in_funct3     = 3'd0;
    in_byte_off   = 2'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
  endtask

  // Issue one load, hold off the response for nwait cycles of in_ready low,
  // then check the writeback/fault cycle and that the fault is a single pulse.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] rd, input logic rw, input int nwait,
                         input logic [31:0] resp, input logic err, input logic early,
                         input logic exp_we, input logic [31:0] exp_data,
                         input logic exp_fault);
    in_valid     = 1'b1;
    in_wb_sel    = 2'd1;
    in_funct3    = f3;
    in_byte_off  = off;
    in_rd        = rd;
    in_reg_write = rw;
    in_alu_data  = 32'hA5A5_A5A5;
    if (early) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1234_5678;
    end
    tick();
    idle_inputs();
    chk({name, "_pending"}, {63'd0, load_pending}, 64'd1);
    chk({name, "_pending_rd"}, {59'd0, load_pending_rd}, {59'd0, rd});
    for (int i = 0; i < nwait; i++) begin
      chk({name, "_ready_low"}, {63'd0, in_ready}, 64'd0);
      chk({name, "_no_we_wait"}, {63'd0, rf_we}, 64'd0);
      if (i != nwait - 1) tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = resp;
    mem_rsp_err   = err;
    tick();
    idle_inputs();
    chk({name, "_we"}, {63'd0, rf_we}, {63'd0, exp_we});
    if (exp_we) begin
      chk({name, "_waddr"}, {59'd0, rf_waddr}, {59'd0, rd});
      chk({name, "_wdata"}, {32'd0, rf_wdata}, {32'd0, exp_data});
    end
    chk({name, "_fault"}, {63'd0, load_fault}, {63'd0, exp_fault});
    chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    chk({name, "_pending_clr"}, {63'd0, load_pending}, 64'd0);
    if (!exp_fault) exp_instret++;
    chk_instret({name, "_instret"});
    tick();
    chk({name, "_fault_pulse"}, {63'd0, load_fault}, 64'd0);
    chk({name, "_we_pulse"}, {63'd0, rf_we}, 64'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{pc: 32'h0000_0000, alu: 32'h0000_1234, rd: 5'd5,  rw: 1'b1, sel: 2'd0, we: 1'b1, wdata: 32'h0000_1234};
    vecs[1] = '{pc: 32'h0000_0100, alu: 32'h0000_DEAD, rd: 5'd1,  rw: 1'b1, sel: 2'd2, we: 1'b1, wdata: 32'h0000_0104};
    vecs[2] = '{pc: 32'h0000_0200, alu: 32'hCAFE_F00D, rd: 5'd31, rw: 1'b1, sel: 2'd3, we: 1'b1, wdata: 32'hCAFE_F00D};
    vecs[3] = '{pc: 32'hFFFF_FFFC, alu: 32'h0000_0077, rd: 5'd7,  rw: 1'b1, sel: 2'd2, we: 1'b1, wdata: 32'h0000_0000};
    vecs[4] = '{pc: 32'h0000_0300, alu: 32'h0000_0055, rd: 5'd9,  rw: 1'b0, sel: 2'd0, we: 1'b0, wdata: 32'h0000_0000};
    vecs[5] = '{pc: 32'h0000_0400, alu: 32'h0000_0066, rd: 5'd0,  rw: 1'b1, sel: 2'd0, we: 1'b0, wdata: 32'h0000_0000};

    idle_inputs();
    rst_n = 1'b0;
    tick();
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("rst_pending", {63'd0, load_pending}, 64'd0);
    chk("rst_pending_rd", {59'd0, load_pending_rd}, 64'd0);
    chk("rst_fault", {63'd0, load_fault}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk_instret("rst_instret");

    // Back-to-back non-load instructions, one per cycle.
    for (int i = 0; i < 6; i++) begin
      in_valid     = 1'b1;
      in_pc        = vecs[i].pc;
      in_alu_data  = vecs[i].alu;
      in_rd        = vecs[i].rd;
      in_reg_write = vecs[i].rw;
      in_wb_sel    = vecs[i].sel;
      tick();
      exp_instret++;
      chk($sformatf("vec%0d_we", i), {63'd0, rf_we}, {63'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].rd});
        chk($sformatf("vec%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].wdata});
      end
      chk($sformatf("vec%0d_ready", i), {63'd0, in_ready}, 64'd1);
      chk($sformatf("vec%0d_fault", i), {63'd0, load_fault}, 64'd0);
    end
    idle_inputs();
    chk_instret("vec_instret");
    tick();
    chk("vec_idle_we", {63'd0, rf_we}, 64'd0);

    // Stray response while idle must not write.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    chk("idle_rsp_we", {63'd0, rf_we}, 64'd0);
    chk("idle_rsp_fault", {63'd0, load_fault}, 64'd0);

    do_load("lb",   3'd0, 2'd3, 5'd10, 1'b1, 3, 32'h80FF_FF00, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0);
    do_load("lbu",  3'd4, 2'd3, 5'd11, 1'b1, 3, 32'h80FF_FF00, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    do_load("lh1",  3'd1, 2'd1, 5'd12, 1'b1, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
    do_load("lhu2", 3'd5, 2'd2, 5'd13, 1'b1, 2, 32'hBEEF_0000, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0);
    do_load("lh2",  3'd1, 2'd2, 5'd14, 1'b1, 1, 32'hBEEF_0000, 1'b0, 1'b0, 1'b1, 32'hFFFF_BEEF, 1'b0);
    do_load("lb1",  3'd0, 2'd1, 5'd15, 1'b1, 1, 32'h0000_7F00, 1'b0, 1'b0, 1'b1, 32'h0000_007F, 1'b0);
    do_load("lw",   3'd2, 2'd0, 5'd16, 1'b1, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_load("lwrd0",3'd2, 2'd0, 5'd0,  1'b1, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
    do_load("lwerr",3'd2, 2'd0, 5'd17, 1'b1, 2, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1);
    do_load("lwmis",3'd2, 2'd2, 5'd18, 1'b1, 1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
    do_load("f3ill",3'd6, 2'd0, 5'd19, 1'b1, 1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
    do_load("lwnrw",3'd2, 2'd0, 5'd20, 1'b0, 1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0);

    // Asynchronous reset in the middle of a pending load.
    in_valid     = 1'b1;
    in_wb_sel    = 2'd1;
    in_funct3    = 3'd2;
    in_rd        = 5'd21;
    in_reg_write = 1'b1;
    tick();
    idle_inputs();
    chk("rstmid_pending", {63'd0, load_pending}, 64'd1);
    tick();
    rst_n = 1'b0;
    #2;
    exp_instret = 0;
    chk("rstmid_ready", {63'd0, in_ready}, 64'd1);
    chk("rstmid_pending_clr", {63'd0, load_pending}, 64'd0);
    chk("rstmid_pending_rd", {59'd0, load_pending_rd}, 64'd0);
    chk("rstmid_wdata", {32'd0, rf_wdata}, 64'd0);
    chk_instret("rstmid_instret");
    #2;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5555_5555;
    tick();
    idle_inputs();
    chk("rstmid_late_we", {63'd0, rf_we}, 64'd0);
    chk("rstmid_late_fault", {63'd0, load_fault}, 64'd0);
    chk("rstmid_late_ready", {63'd0, in_ready}, 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
